// File: rtl/daq_pkg.sv
// Shared encodings for the DAQ sensor pattern generator: pattern modes, FSM states, PRBS-15 constants.
package daq_pkg;

  localparam logic [2:0] MODE_CONST = 3'd0;
  localparam logic [2:0] MODE_HRAMP = 3'd1;
  localparam logic [2:0] MODE_VRAMP = 3'd2;
  localparam logic [2:0] MODE_ALT   = 3'd3;
  localparam logic [2:0] MODE_WALK  = 3'd4;
  localparam logic [2:0] MODE_PRBS  = 3'd5;

  typedef enum logic [1:0] {IDLE, V_ACT, V_BLK, DONE} state_t;

  localparam logic [14:0] PRBS_SEED  = 15'h7FFF;
  localparam int          PRBS_TAP_A = 14;
  localparam int          PRBS_TAP_B = 13;

  // x^15 + x^14 + 1, shifting towards the MSB
  function automatic logic [14:0] prbs15_step(input logic [14:0] s);
    return {s[13:0], s[PRBS_TAP_A] ^ s[PRBS_TAP_B]};
  endfunction

endpackage

// File: rtl/daq_timing_gen.sv
// Pixel divider, h/v raster counters and frame FSM; everything except pix_clk moves only on tick,
// the clk edge where pix_clk falls, so sensor-side signals are stable at the pix_clk rising edge.
module daq_timing_gen #(
  parameter int PIX_DIV    = 4,
  parameter int H_ACTIVE   = 100,
  parameter int H_BLANK    = 20,
  parameter int V_ACTIVE   = 20,
  parameter int V_BLANK    = 4,
  parameter int NUM_FRAMES = 0
) (
  input  logic        clk,
  input  logic        sys_rst_n,
  input  logic        enable,
  output logic        tick,
  output logic        frame_start,
  output logic        pix_clk,
  output logic        line_valid,
  output logic        frame_valid,
  output logic        frame_done,
  output logic [15:0] h_cnt,
  output logic [15:0] v_cnt,
  output logic [15:0] frame_cnt
);
  import daq_pkg::*;

  localparam int              DIV_W    = $clog2(PIX_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(PIX_DIV / 2);
  localparam logic [15:0]     H_LAST   = 16'(H_ACTIVE + H_BLANK - 1);
  localparam logic [15:0]     V_LAST   = 16'(V_ACTIVE + V_BLANK - 1);
  localparam logic [15:0]     H_ACT16  = 16'(H_ACTIVE);
  localparam logic [15:0]     V_ACT16  = 16'(V_ACTIVE);
  localparam logic [15:0]     NF16     = 16'(NUM_FRAMES);

  state_t           state;
  logic [DIV_W-1:0] div_cnt, div_nxt;
  logic [15:0]      h_nxt, v_nxt, run_cnt;
  logic             h_last, frame_end, run_done;

  assign tick      = (div_cnt == DIV_LAST);
  assign div_nxt   = tick ? '0 : div_cnt + 1'b1;
  assign h_last    = (h_cnt == H_LAST);
  assign h_nxt     = h_last ? 16'd0 : h_cnt + 16'd1;
  assign v_nxt     = !h_last ? v_cnt : ((v_cnt == V_LAST) ? 16'd0 : v_cnt + 16'd1);
  assign frame_end = ((state == V_ACT) || (state == V_BLK)) && h_last && (v_cnt == V_LAST);
  assign run_done  = (NF16 != 16'd0) && (run_cnt + 16'd1 == NF16);
  assign frame_start = tick && enable &&
                       ((state == IDLE) || (frame_end && !run_done));

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= IDLE;
      div_cnt     <= '0;
      pix_clk     <= 1'b0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      run_cnt     <= '0;
      frame_cnt   <= '0;
      line_valid  <= 1'b0;
      frame_valid <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      div_cnt    <= div_nxt;
      pix_clk    <= (div_nxt >= DIV_HALF);
      frame_done <= 1'b0;
      if (tick) begin
        case (state)
          IDLE: begin
            if (enable) begin
              state       <= V_ACT;
              h_cnt       <= '0;
              v_cnt       <= '0;
              frame_valid <= 1'b1;
              line_valid  <= 1'b1;
            end
          end
          V_ACT, V_BLK: begin
            if (frame_end) begin
              frame_done <= 1'b1;
              frame_cnt  <= frame_cnt + 16'd1;
              run_cnt    <= run_cnt + 16'd1;
              h_cnt      <= '0;
              v_cnt      <= '0;
              if (run_done) begin
                state       <= DONE;
                frame_valid <= 1'b0;
                line_valid  <= 1'b0;
              end else if (enable) begin
                state       <= V_ACT;
                frame_valid <= 1'b1;
                line_valid  <= 1'b1;
              end else begin
                state       <= IDLE;
                frame_valid <= 1'b0;
                line_valid  <= 1'b0;
              end
            end else begin
              h_cnt       <= h_nxt;
              v_cnt       <= v_nxt;
              state       <= (v_nxt < V_ACT16) ? V_ACT : V_BLK;
              frame_valid <= (v_nxt < V_ACT16);
              line_valid  <= (v_nxt < V_ACT16) && (h_nxt < H_ACT16);
            end
          end
          DONE: begin
            if (!enable) begin
              state   <= IDLE;
              run_cnt <= '0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/daq_pattern_gen.sv
// Image-sensor pattern generator top: mode latch and pixel pattern mux over the raster timing.
// Mode 5 is PRBS-15 when DAQ_PATGEN_PRBS_EN is defined, otherwise it falls back to the constant pattern.
module daq_pattern_gen #(
  parameter int DATA_W     = 8,
  parameter int PIX_DIV    = 4,
  parameter int H_ACTIVE   = 100,
  parameter int H_BLANK    = 20,
  parameter int V_ACTIVE   = 20,
  parameter int V_BLANK    = 4,
  parameter int NUM_FRAMES = 0
) (
  input  logic              clk,
  input  logic              sys_rst_n,
  input  logic              enable,
  input  logic [2:0]        mode,
  input  logic [DATA_W-1:0] const_val,
  output logic              pix_clk,
  output logic [DATA_W-1:0] pix_data,
  output logic              line_valid,
  output logic              frame_valid,
  output logic              frame_done,
  output logic [15:0]       frame_cnt
);
  import daq_pkg::*;

  localparam logic [15:0] DW16 = 16'(DATA_W);

  logic              tick, frame_start;
  logic [15:0]       h_cnt, v_cnt;
  logic [2:0]        mode_q;
  logic [DATA_W-1:0] const_q, pat;

  daq_timing_gen #(
    .PIX_DIV    (PIX_DIV),
    .H_ACTIVE   (H_ACTIVE),
    .H_BLANK    (H_BLANK),
    .V_ACTIVE   (V_ACTIVE),
    .V_BLANK    (V_BLANK),
    .NUM_FRAMES (NUM_FRAMES)
  ) u_timing (
    .clk         (clk),
    .sys_rst_n   (sys_rst_n),
    .enable      (enable),
    .tick        (tick),
    .frame_start (frame_start),
    .pix_clk     (pix_clk),
    .line_valid  (line_valid),
    .frame_valid (frame_valid),
    .frame_done  (frame_done),
    .h_cnt       (h_cnt),
    .v_cnt       (v_cnt),
    .frame_cnt   (frame_cnt)
  );

  // const_val is sampled on tick so pix_data never moves between pixel boundaries
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      mode_q  <= MODE_CONST;
      const_q <= '0;
    end else begin
      if (frame_start) mode_q <= mode;
      if (tick)        const_q <= const_val;
    end
  end

`ifdef DAQ_PATGEN_PRBS_EN
  logic [14:0] lfsr;

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      lfsr <= PRBS_SEED;
    end else if (frame_start) begin
      lfsr <= PRBS_SEED;
    end else if (tick && line_valid) begin
      lfsr <= prbs15_step(lfsr);
    end
  end
`endif

  always_comb begin
    pat = const_q;
    case (mode_q)
      MODE_HRAMP: pat = DATA_W'(h_cnt);
      MODE_VRAMP: pat = DATA_W'(v_cnt);
      MODE_ALT:   pat = {DATA_W{h_cnt[0]}};
      MODE_WALK:  pat = {{(DATA_W-1){1'b0}}, 1'b1} << (h_cnt % DW16);
`ifdef DAQ_PATGEN_PRBS_EN
      MODE_PRBS:  pat = lfsr[DATA_W-1:0];
`endif
      default:    pat = const_q;
    endcase
  end

  assign pix_data = line_valid ? pat : '0;

endmodule

// File: tb/tb_daq_pattern_gen.sv
// Directed bench for daq_pattern_gen: 4x3 active raster, 2 blank pixels, 1 blank line, 2-frame runs.
module tb_daq_pattern_gen;

  logic        clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [2:0]  mode = 3'd0;
  logic [7:0]  const_val = 8'h00;
  logic        pix_clk, line_valid, frame_valid, frame_done;
  logic [7:0]  pix_data;
  logic [15:0] frame_cnt;

  int n_chk = 0;
  int n_fail = 0;
  int n_done = 0;
  int stab_err = 0;
  bit mon_en = 1'b0;

  logic [7:0] prbs_tab [4] = '{8'hFF, 8'hFE, 8'hFC, 8'hF8};
  logic [7:0] pc_exp = 8'b1001_1001;

  always #5 clk = ~clk;

  daq_pattern_gen #(
    .DATA_W(8), .PIX_DIV(4), .H_ACTIVE(4), .H_BLANK(2),
    .V_ACTIVE(3), .V_BLANK(1), .NUM_FRAMES(2)
  ) dut (
    .clk         (clk),
    .sys_rst_n   (sys_rst_n),
    .enable      (enable),
    .mode        (mode),
    .const_val   (const_val),
    .pix_clk     (pix_clk),
    .pix_data    (pix_data),
    .line_valid  (line_valid),
    .frame_valid (frame_valid),
    .frame_done  (frame_done),
    .frame_cnt   (frame_cnt)
  );

  always @(negedge clk) if (frame_done === 1'b1) n_done++;

  // Sensor-side signals may only move on the clk edge where pix_clk falls
  logic [7:0] pd_q = 8'h00;
  logic lv_q = 1'b0, fv_q = 1'b0, pc_q = 1'b0;
  always @(posedge clk) begin
    #1;
    if (mon_en && (pix_data !== pd_q || line_valid !== lv_q || frame_valid !== fv_q)
        && !(pc_q === 1'b1 && pix_clk === 1'b0))
      stab_err++;
    pd_q = pix_data;
    lv_q = line_valid;
    fv_q = frame_valid;
    pc_q = pix_clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next pix_clk rising edge
  task automatic next_pix();
    bit low_seen = 1'b0;
    bit found = 1'b0;
    for (int n = 0; n < 16 && !found; n++) begin
      @(posedge clk); #1;
      if (pix_clk === 1'b0) low_seen = 1'b1;
      else if (low_seen && pix_clk === 1'b1) found = 1'b1;
    end
    if (!found) chk("pix_clk_rise", 32'(found), 32'd1);
  endtask

  task automatic sync_frame();
    int n = 0;
    do begin
      next_pix();
      n++;
    end while (frame_valid !== 1'b1 && n < 60);
    if (frame_valid !== 1'b1) chk("frame_start_wait", 32'(frame_valid), 32'd1);
  endtask

  function automatic logic [7:0] exp_data(input int md, input int h, input int v);
    case (md)
      1: return 8'(h);
      2: return 8'(v);
      3: return (h % 2 == 1) ? 8'hFF : 8'h00;
      4: return 8'h01 << (h % 8);
`ifdef DAQ_PATGEN_PRBS_EN
      5: return prbs_tab[h % 4];
`endif
      default: return const_val;
    endcase
  endfunction

  // Pixel p = line*6 + column; current sample must be pixel 'first'
  task automatic check_pixels(input int first, input int last, input int md);
    int h, v;
    bit lv, skip;
    for (int p = first; p <= last; p++) begin
      h = p % 6;
      v = p / 6;
      lv = (v < 3) && (h < 4);
      skip = 1'b0;
`ifdef DAQ_PATGEN_PRBS_EN
      skip = (md == 5) && (v > 0) && lv;
`endif
      chk("frame_valid", 32'(frame_valid), 32'(v < 3));
      chk("line_valid", 32'(line_valid), 32'(lv));
      if (!skip) chk("pix_data", 32'(pix_data), lv ? 32'(exp_data(md, h, v)) : 32'd0);
      next_pix();
    end
  endtask

  task automatic check_idle(input int n, input int fcnt);
    for (int i = 0; i < n; i++) begin
      chk("idle_frame_valid", 32'(frame_valid), 32'd0);
      chk("idle_line_valid", 32'(line_valid), 32'd0);
      chk("idle_pix_data", 32'(pix_data), 32'd0);
      chk("idle_frame_cnt", 32'(frame_cnt), 32'(fcnt));
      next_pix();
    end
  endtask

  initial begin
    #12;
    chk("rst_pix_clk", 32'(pix_clk), 32'd0);
    chk("rst_pix_data", 32'(pix_data), 32'd0);
    chk("rst_line_valid", 32'(line_valid), 32'd0);
    chk("rst_frame_valid", 32'(frame_valid), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    @(negedge clk) sys_rst_n = 1'b1;
    repeat (2) @(posedge clk);
    mon_en = 1'b1;

    // Divider free-runs in IDLE: 2 clk low, 2 clk high
    next_pix();
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("pix_clk_shape", 32'(pix_clk), 32'(pc_exp[i]));
    end
    check_idle(2, 0);

    // Ramp frame, mode change mid-frame takes effect on the next frame, run stops after 2
    mode = 3'd1;
    enable = 1'b1;
    sync_frame();
    check_pixels(0, 5, 1);
    mode = 3'd3;
    check_pixels(6, 23, 1);
    chk("frame_cnt_f1", 32'(frame_cnt), 32'd1);
    chk("done_pulses_f1", 32'(n_done), 32'd1);
    check_pixels(0, 23, 3);
    chk("frame_cnt_run1", 32'(frame_cnt), 32'd2);
    chk("done_pulses_run1", 32'(n_done), 32'd2);
    check_idle(4, 2);

    // Leave DONE, start a fresh run in vertical-ramp mode
    enable = 1'b0;
    next_pix();
    enable = 1'b1;
    mode = 3'd2;
    sync_frame();
    check_pixels(0, 23, 2);
    check_pixels(0, 23, 2);
    chk("frame_cnt_run2", 32'(frame_cnt), 32'd4);
    chk("done_pulses_run2", 32'(n_done), 32'd4);
    check_idle(2, 4);

    // enable dropped during line 1: frame still completes, then IDLE
    enable = 1'b0;
    next_pix();
    mode = 3'd4;
    enable = 1'b1;
    sync_frame();
    check_pixels(0, 7, 4);
    enable = 1'b0;
    check_pixels(8, 23, 4);
    chk("done_pulses_drop", 32'(n_done), 32'd5);
    check_idle(3, 5);

    // Asynchronous reset in the middle of an active line
    mode = 3'd0;
    const_val = 8'hA5;
    enable = 1'b1;
    sync_frame();
    check_pixels(0, 1, 0);
    mon_en = 1'b0;
    #2 sys_rst_n = 1'b0;
    #1;
    chk("arst_pix_clk", 32'(pix_clk), 32'd0);
    chk("arst_pix_data", 32'(pix_data), 32'd0);
    chk("arst_line_valid", 32'(line_valid), 32'd0);
    chk("arst_frame_valid", 32'(frame_valid), 32'd0);
    chk("arst_frame_cnt", 32'(frame_cnt), 32'd0);
    enable = 1'b0;
    @(negedge clk);
    @(negedge clk) sys_rst_n = 1'b1;
    repeat (2) @(posedge clk);
    mon_en = 1'b1;
    check_idle(3, 0);

    // Constant frame, then PRBS (or constant fallback) frames restarting at each frame start
    enable = 1'b1;
    sync_frame();
    check_pixels(0, 11, 0);
    mode = 3'd5;
    check_pixels(12, 23, 0);
    check_pixels(0, 23, 5);
    chk("frame_cnt_run3", 32'(frame_cnt), 32'd2);
    enable = 1'b0;
    next_pix();
    enable = 1'b1;
    sync_frame();
    check_pixels(0, 23, 5);
    chk("frame_cnt_run4", 32'(frame_cnt), 32'd3);

    chk("data_stable_at_rise", 32'(stab_err), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
